// File: rtl/spiral_multi_gen_if.sv
// spiral_multi_gen_if: pixel/control bus for spiral_multi_gen.
// master drives pattern_enable, x, y, active, next_frame, step_size, dir,
// palette_cycle; slave returns rgb, rot_angle, reversing.
interface spiral_multi_gen_if #(
   parameter int ANGLE_W = 6
);
   logic               pattern_enable;
   logic [9:0]         x;
   logic [9:0]         y;
   logic               active;
   logic               next_frame;
   logic [2:0]         step_size;
   logic               dir;
   logic               palette_cycle;
   logic [5:0]         rgb;
   logic [ANGLE_W-1:0] rot_angle;
   logic               reversing;
   modport master (
      output pattern_enable, x, y, active, next_frame, step_size, dir, palette_cycle,
      input  rgb, rot_angle, reversing
   );
   modport slave (
      input  pattern_enable, x, y, active, next_frame, step_size, dir, palette_cycle,
      output rgb, rot_angle, reversing
   );
endinterface

// File: rtl/spiral_multi_gen.sv
// spiral_multi_gen: rotating multi-arm spiral with braked reversal and palette cycling.
// Ports: clk, rst_n (async active-low), bus (slave): pixel x/y/active, frame tick
// controls in, registered rgb plus rot_angle/reversing observation out.
module spiral_multi_gen #(
   parameter int NUM_ARMS     = 6,
   parameter int ANGLE_W      = 6,
   parameter int CENTER_X     = 320,
   parameter int CENTER_Y     = 240,
   parameter int RADIUS_SHIFT = 4,
   parameter int MIN_RADIUS   = 20,
   parameter int PAL_DIV      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   spiral_multi_gen_if.slave   bus
);
   typedef enum logic [1:0] {RUN = 2'd0, BRAKE = 2'd1, RAMP = 2'd2} state_t;
   localparam logic [9:0]  CX = 10'(CENTER_X);
   localparam logic [9:0]  CY = 10'(CENTER_Y);
   localparam logic [10:0] MR = 11'(MIN_RADIUS);
   localparam logic [3:0]  NA = 4'(NUM_ARMS);
   localparam logic [5:0]  LUT [8] = '{6'b010001, 6'b100011, 6'b111010, 6'b001110,
                                       6'b011101, 6'b101111, 6'b110100, 6'b000111};
   state_t               state_q, state_d;
   logic [ANGLE_W+1:0]   acc_q, acc_d;
   logic [2:0]           spd_q, spd_d;
   logic                 cur_dir_q, cur_dir_d;
   logic [PAL_DIV-1:0]   cnt_q, cnt_d;
   logic [2:0]           shift_q, shift_d;
   logic [5:0]           rgb_q, rgb_d;
   logic                 reversing_q, reversing_d;
   logic                 tick;
   logic [3:0]           spd_inc;
   logic                 x_ge, y_ge;
   logic [9:0]           dx, dy;
   logic [10:0]          radius;
   logic [2:0]           sector;
   logic [ANGLE_W-1:0]   angle, phase;
   logic [ANGLE_W+2:0]   prod;
   logic [2:0]           arm, idx;
   logic [3:0]           idx_sum;
   logic                 in_arm;
   // Frame state: speed/direction FSM, accumulator and palette shift.
   always_comb begin
      tick        = bus.pattern_enable && bus.next_frame;
      spd_inc     = {1'b0, spd_q} + 4'd1;
      acc_d       = acc_q;
      spd_d       = spd_q;
      state_d     = state_q;
      cur_dir_d   = cur_dir_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      if (tick) begin
         // Accumulator always uses the speed held before this tick.
         acc_d = cur_dir_q ? acc_q - (ANGLE_W+2)'(spd_q) : acc_q + (ANGLE_W+2)'(spd_q);
         if (state_q == RUN) begin
            if (bus.dir != cur_dir_q) state_d = BRAKE;
            else spd_d = bus.step_size;
         end else if (state_q == BRAKE) begin
            if (spd_q == 3'd0) begin
               cur_dir_d = bus.dir;
               state_d   = RAMP;
            end else begin
               spd_d = spd_q - 3'd1;
               // Request withdrawn before standstill: accelerate again without flipping.
               if (bus.dir == cur_dir_q) state_d = RAMP;
            end
         end else begin
            if (spd_inc >= {1'b0, bus.step_size}) begin
               spd_d   = bus.step_size;
               state_d = RUN;
            end else spd_d = spd_inc[2:0];
         end
         if (bus.palette_cycle) begin
            cnt_d = cnt_q + PAL_DIV'(1);
            if (cnt_d == '0) shift_d = (shift_q == 3'(NUM_ARMS - 1)) ? 3'd0 : shift_q + 3'd1;
         end
      end
      reversing_d = state_d != RUN;
   end
   // Per-pixel geometry: octant sector plus rotation, twisted by radius.
   always_comb begin
      x_ge    = bus.x >= CX;
      y_ge    = bus.y >= CY;
      dx      = x_ge ? bus.x - CX : CX - bus.x;
      dy      = y_ge ? bus.y - CY : CY - bus.y;
      radius  = {1'b0, dx} + {1'b0, dy};
      sector  = {x_ge, y_ge, dx > dy};
      angle   = {sector, {(ANGLE_W-3){1'b0}}} + acc_q[ANGLE_W+1:2];
      phase   = angle - ANGLE_W'(radius >> RADIUS_SHIFT);
      prod    = (ANGLE_W+3)'(phase) * (ANGLE_W+3)'(NUM_ARMS);
      arm     = prod[ANGLE_W+2:ANGLE_W];
      in_arm  = !prod[ANGLE_W-1] && (radius > MR);
      idx_sum = {1'b0, arm} + {1'b0, shift_q};
      idx     = (idx_sum >= NA) ? 3'(idx_sum - NA) : idx_sum[2:0];
      rgb_d   = (bus.pattern_enable && bus.active && in_arm) ? LUT[idx] : 6'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         acc_q       <= '0;
         spd_q       <= '0;
         cur_dir_q   <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         rgb_q       <= '0;
         reversing_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         spd_q       <= spd_d;
         cur_dir_q   <= cur_dir_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rgb_q       <= rgb_d;
         reversing_q <= reversing_d;
      end
   end
   assign bus.rgb       = rgb_q;
   assign bus.rot_angle = acc_q[ANGLE_W+1:2];
   assign bus.reversing = reversing_q;
endmodule
